// File: rtl/sysio_axil_arb_pkg.sv
// Shared definitions for the sysio AXI4-Lite two-master arbiter:
// bus widths and the arbiter state encoding.
package sysio_axil_arb_pkg;

  localparam int MEM_ADDR_BUS = 32;
  localparam int MEM_BUS      = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WGNT  = 2'd1,
    RGNT  = 2'd2,
    RRESP = 2'd3
  } arb_state_t;

endpackage

// File: rtl/axil_rr_pick2.sv
// Two-input round-robin picker. A lone requester always wins. On a tie,
// rr decides, unless lock forces master 1.
module axil_rr_pick2
  import sysio_axil_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr,
  input  logic       lock,
  output logic       g
);

  logic both;

  assign both = req[0] & req[1];
  assign g    = (lock & req[1]) | (both ? rr : req[1]);

endmodule

// File: rtl/sysio_axil_arb.sv
// Two-master to one-slave AXI4-Lite arbiter (AW/W/AR/R only) in front of sysio.
// Define SYSIO_ARB_LOCK_EN to add m1_lock_i, which lets m1 hold the bus.
module sysio_axil_arb
  import sysio_axil_arb_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_BUS,
  parameter int DATA_W = MEM_BUS
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef SYSIO_ARB_LOCK_EN
  input  logic                m1_lock_i,
`endif
  input  logic [ADDR_W-1:0]   m0_axi_awaddr,
  input  logic                m0_axi_awvalid,
  output logic                m0_axi_awready,
  input  logic [DATA_W-1:0]   m0_axi_wdata,
  input  logic [DATA_W/8-1:0] m0_axi_wstrb,
  input  logic                m0_axi_wvalid,
  output logic                m0_axi_wready,
  input  logic [ADDR_W-1:0]   m0_axi_araddr,
  input  logic                m0_axi_arvalid,
  output logic                m0_axi_arready,
  output logic [DATA_W-1:0]   m0_axi_rdata,
  output logic                m0_axi_rvalid,
  input  logic                m0_axi_rready,
  input  logic [ADDR_W-1:0]   m1_axi_awaddr,
  input  logic                m1_axi_awvalid,
  output logic                m1_axi_awready,
  input  logic [DATA_W-1:0]   m1_axi_wdata,
  input  logic [DATA_W/8-1:0] m1_axi_wstrb,
  input  logic                m1_axi_wvalid,
  output logic                m1_axi_wready,
  input  logic [ADDR_W-1:0]   m1_axi_araddr,
  input  logic                m1_axi_arvalid,
  output logic                m1_axi_arready,
  output logic [DATA_W-1:0]   m1_axi_rdata,
  output logic                m1_axi_rvalid,
  input  logic                m1_axi_rready,
  output logic [ADDR_W-1:0]   s_axi_awaddr,
  output logic                s_axi_awvalid,
  input  logic                s_axi_awready,
  output logic [DATA_W-1:0]   s_axi_wdata,
  output logic [DATA_W/8-1:0] s_axi_wstrb,
  output logic                s_axi_wvalid,
  input  logic                s_axi_wready,
  output logic [ADDR_W-1:0]   s_axi_araddr,
  output logic                s_axi_arvalid,
  input  logic                s_axi_arready,
  input  logic [DATA_W-1:0]   s_axi_rdata,
  input  logic                s_axi_rvalid,
  output logic                s_axi_rready
);

  // Per-master views so the granted master can be indexed by g_reg.
  logic [ADDR_W-1:0]   awaddr [2];
  logic [DATA_W-1:0]   wdata  [2];
  logic [DATA_W/8-1:0] wstrb  [2];
  logic [ADDR_W-1:0]   araddr [2];
  logic [DATA_W-1:0]   rdata  [2];
  logic [1:0] awvalid, wvalid, arvalid, rready;
  logic [1:0] awready, wready, arready, rvalid;
  logic [1:0] wreq, req;

  arb_state_t state;
  logic       g_reg, rr_reg, lock_reg;
  logic       pick_g, lock, lock_hit;
  logic       in_w, in_r, in_rr;

  assign awaddr[0] = m0_axi_awaddr;
  assign awaddr[1] = m1_axi_awaddr;
  assign wdata[0]  = m0_axi_wdata;
  assign wdata[1]  = m1_axi_wdata;
  assign wstrb[0]  = m0_axi_wstrb;
  assign wstrb[1]  = m1_axi_wstrb;
  assign araddr[0] = m0_axi_araddr;
  assign araddr[1] = m1_axi_araddr;
  assign awvalid   = {m1_axi_awvalid, m0_axi_awvalid};
  assign wvalid    = {m1_axi_wvalid,  m0_axi_wvalid};
  assign arvalid   = {m1_axi_arvalid, m0_axi_arvalid};
  assign rready    = {m1_axi_rready,  m0_axi_rready};

  assign m0_axi_awready = awready[0];
  assign m1_axi_awready = awready[1];
  assign m0_axi_wready  = wready[0];
  assign m1_axi_wready  = wready[1];
  assign m0_axi_arready = arready[0];
  assign m1_axi_arready = arready[1];
  assign m0_axi_rvalid  = rvalid[0];
  assign m1_axi_rvalid  = rvalid[1];
  assign m0_axi_rdata   = rdata[0];
  assign m1_axi_rdata   = rdata[1];

  assign wreq = awvalid & wvalid;
  assign req  = wreq | arvalid;

`ifdef SYSIO_ARB_LOCK_EN
  assign lock = m1_lock_i;
`else
  assign lock = 1'b0;
`endif
  assign lock_hit = lock & req[1];

  axil_rr_pick2 u_pick (
    .req  (req),
    .rr   (rr_reg),
    .lock (lock),
    .g    (pick_g)
  );

  assign in_w  = (state == WGNT);
  assign in_r  = (state == RGNT);
  assign in_rr = (state == RRESP);

  assign s_axi_awaddr  = in_w ? awaddr[g_reg] : '0;
  assign s_axi_wdata   = in_w ? wdata[g_reg]  : '0;
  assign s_axi_wstrb   = in_w ? wstrb[g_reg]  : '0;
  assign s_axi_awvalid = in_w & awvalid[g_reg];
  assign s_axi_wvalid  = in_w & wvalid[g_reg];
  assign s_axi_araddr  = in_r ? araddr[g_reg] : '0;
  assign s_axi_arvalid = in_r & arvalid[g_reg];
  assign s_axi_rready  = in_rr & rready[g_reg];

  for (genvar gi = 0; gi < 2; gi++) begin : g_master
    logic sel;
    assign sel         = (g_reg == 1'(gi));
    assign awready[gi] = in_w & sel & s_axi_awready;
    assign wready[gi]  = in_w & sel & s_axi_wready;
    assign arready[gi] = in_r & sel & s_axi_arready;
    assign rvalid[gi]  = in_rr & sel & s_axi_rvalid;
    assign rdata[gi]   = (in_rr & sel) ? s_axi_rdata : '0;
  end

  // A locked grant leaves rr alone so m0 keeps its turn once the lock drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      g_reg    <= 1'b0;
      rr_reg   <= 1'b0;
      lock_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            g_reg    <= pick_g;
            lock_reg <= lock_hit;
            state    <= wreq[pick_g] ? WGNT : RGNT;
          end
        end
        WGNT: begin
          if (!wreq[g_reg]) begin
            state <= IDLE;
          end else if (s_axi_awready && s_axi_wready) begin
            state <= IDLE;
            if (!lock_reg) rr_reg <= ~g_reg;
          end
        end
        RGNT: begin
          if (!arvalid[g_reg]) begin
            state <= IDLE;
          end else if (s_axi_arready) begin
            state <= RRESP;
          end
        end
        RRESP: begin
          if (s_axi_rvalid && rready[g_reg]) begin
            state <= IDLE;
            if (!lock_reg) rr_reg <= ~g_reg;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysio_axil_arb.sv
// Directed self-checking bench for sysio_axil_arb; lock steps run only when
// SYSIO_ARB_LOCK_EN is defined.
module tb_sysio_axil_arb;

  logic        clk, rst_n;
  logic [31:0] m0_awaddr, m0_wdata, m0_araddr, m0_rdata;
  logic [3:0]  m0_wstrb;
  logic        m0_awvalid, m0_awready, m0_wvalid, m0_wready;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [31:0] m1_awaddr, m1_wdata, m1_araddr, m1_rdata;
  logic [3:0]  m1_wstrb;
  logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]  s_wstrb;
  logic        s_awvalid, s_awready, s_wvalid, s_wready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic        m1_lock;

  int checks = 0;
  int errors = 0;

  sysio_axil_arb dut (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef SYSIO_ARB_LOCK_EN
    .m1_lock_i      (m1_lock),
`endif
    .m0_axi_awaddr  (m0_awaddr),  .m0_axi_awvalid (m0_awvalid), .m0_axi_awready (m0_awready),
    .m0_axi_wdata   (m0_wdata),   .m0_axi_wstrb   (m0_wstrb),
    .m0_axi_wvalid  (m0_wvalid),  .m0_axi_wready  (m0_wready),
    .m0_axi_araddr  (m0_araddr),  .m0_axi_arvalid (m0_arvalid), .m0_axi_arready (m0_arready),
    .m0_axi_rdata   (m0_rdata),   .m0_axi_rvalid  (m0_rvalid),  .m0_axi_rready  (m0_rready),
    .m1_axi_awaddr  (m1_awaddr),  .m1_axi_awvalid (m1_awvalid), .m1_axi_awready (m1_awready),
    .m1_axi_wdata   (m1_wdata),   .m1_axi_wstrb   (m1_wstrb),
    .m1_axi_wvalid  (m1_wvalid),  .m1_axi_wready  (m1_wready),
    .m1_axi_araddr  (m1_araddr),  .m1_axi_arvalid (m1_arvalid), .m1_axi_arready (m1_arready),
    .m1_axi_rdata   (m1_rdata),   .m1_axi_rvalid  (m1_rvalid),  .m1_axi_rready  (m1_rready),
    .s_axi_awaddr   (s_awaddr),   .s_axi_awvalid  (s_awvalid),  .s_axi_awready  (s_awready),
    .s_axi_wdata    (s_wdata),    .s_axi_wstrb    (s_wstrb),
    .s_axi_wvalid   (s_wvalid),   .s_axi_wready   (s_wready),
    .s_axi_araddr   (s_araddr),   .s_axi_arvalid  (s_arvalid),  .s_axi_arready  (s_arready),
    .s_axi_rdata    (s_rdata),    .s_axi_rvalid   (s_rvalid),   .s_axi_rready   (s_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; m1_lock = 1'b0;
    m0_awaddr = '0; m0_wdata = '0; m0_wstrb = '0; m0_awvalid = 0; m0_wvalid = 0;
    m0_araddr = '0; m0_arvalid = 0; m0_rready = 0;
    m1_awaddr = '0; m1_wdata = '0; m1_wstrb = '0; m1_awvalid = 0; m1_wvalid = 0;
    m1_araddr = '0; m1_arvalid = 0; m1_rready = 0;
    s_awready = 1; s_wready = 1; s_arready = 1;
    s_rvalid = 1; s_rdata = 32'hDEAD_BEEF;   // stray response during reset and idle
    step(); step();
    smp();
    chk("rst_s_awvalid", s_awvalid, 0);
    chk("rst_s_wvalid", s_wvalid, 0);
    chk("rst_s_arvalid", s_arvalid, 0);
    chk("rst_s_rready", s_rready, 0);
    chk("rst_s_awaddr", s_awaddr, 0);
    chk("rst_m0_awready", m0_awready, 0);
    chk("rst_m1_arready", m1_arready, 0);
    chk("rst_m0_rvalid", m0_rvalid, 0);
    chk("rst_m1_rvalid", m1_rvalid, 0);
    chk("rst_m0_rdata", m0_rdata, 0);

    step(); rst_n = 1'b1;
    smp();
    chk("stray_m0_rvalid", m0_rvalid, 0);
    chk("stray_m1_rdata", m1_rdata, 0);
    chk("stray_s_rready", s_rready, 0);

    // Single write from m0
    step(); s_rvalid = 0; s_rdata = '0;
    m0_awaddr = 32'h0000_0400; m0_wdata = 32'h0000_00FF; m0_wstrb = 4'hF;
    m0_awvalid = 1; m0_wvalid = 1;
    smp();
    chk("wr_idle_awready", m0_awready, 0);
    chk("wr_idle_s_awvalid", s_awvalid, 0);
    step(); smp();
    chk("wr_s_awvalid", s_awvalid, 1);
    chk("wr_s_wvalid", s_wvalid, 1);
    chk("wr_s_awaddr", s_awaddr, 32'h0000_0400);
    chk("wr_s_wdata", s_wdata, 32'h0000_00FF);
    chk("wr_s_wstrb", s_wstrb, 4'hF);
    chk("wr_m0_awready", m0_awready, 1);
    chk("wr_m0_wready", m0_wready, 1);
    chk("wr_m1_awready", m1_awready, 0);
    chk("wr_m1_wready", m1_wready, 0);
    step(); m0_awvalid = 0; m0_wvalid = 0;
    smp();
    chk("wr_done_awready", m0_awready, 0);
    chk("wr_done_wready", m0_wready, 0);
    chk("wr_done_s_awvalid", s_awvalid, 0);

    // Single read from m1, response after 3 cycles
    step(); m1_araddr = 32'h0000_0F00; m1_arvalid = 1; m1_rready = 1;
    smp();
    chk("rd_idle_s_arvalid", s_arvalid, 0);
    step(); smp();
    chk("rd_s_arvalid", s_arvalid, 1);
    chk("rd_s_araddr", s_araddr, 32'h0000_0F00);
    chk("rd_m1_arready", m1_arready, 1);
    chk("rd_m0_arready", m0_arready, 0);
    step(); m1_arvalid = 0;
    smp();
    chk("rd_wait1_s_rready", s_rready, 1);
    chk("rd_wait1_m1_rvalid", m1_rvalid, 0);
    step(); smp();
    chk("rd_wait2_m1_rvalid", m1_rvalid, 0);
    step(); s_rvalid = 1; s_rdata = 32'h1234_5678;
    smp();
    chk("rd_m1_rvalid", m1_rvalid, 1);
    chk("rd_m1_rdata", m1_rdata, 32'h1234_5678);
    chk("rd_m0_rvalid", m0_rvalid, 0);
    chk("rd_m0_rdata", m0_rdata, 0);
    step(); s_rvalid = 0; s_rdata = '0; m1_rready = 0;
    smp();
    chk("rd_done_m1_rvalid", m1_rvalid, 0);
    chk("rd_done_s_rready", s_rready, 0);

    // Contention after reset: grants alternate m0, m1, m0, ...
    step(); rst_n = 0;
    step(); rst_n = 1;
    m0_awaddr = 32'h100; m0_wdata = 32'h1; m0_awvalid = 1; m0_wvalid = 1;
    m1_awaddr = 32'h200; m1_wdata = 32'h2; m1_awvalid = 1; m1_wvalid = 1; m1_wstrb = 4'h3;
    for (int k = 0; k < 12; k++) begin
      smp();
      chk($sformatf("rr_m0_grant_c%0d", k), m0_awready, (k % 4 == 1));
      chk($sformatf("rr_m1_grant_c%0d", k), m1_awready, (k % 4 == 3));
      if (k % 4 == 3) chk($sformatf("rr_s_awaddr_c%0d", k), s_awaddr, 32'h200);
      step();
    end
    m0_awvalid = 0; m0_wvalid = 0; m1_awvalid = 0; m1_wvalid = 0;
    smp();
    chk("rr_done_s_awvalid", s_awvalid, 0);

    // Write before read within one master
    step();
    m0_awaddr = 32'h20; m0_wdata = 32'h55; m0_awvalid = 1; m0_wvalid = 1;
    m0_araddr = 32'h10; m0_arvalid = 1; m0_rready = 1;
    smp();
    chk("pri_idle_arready", m0_arready, 0);
    step(); smp();
    chk("pri_w_awready", m0_awready, 1);
    chk("pri_w_s_awvalid", s_awvalid, 1);
    chk("pri_w_s_arvalid", s_arvalid, 0);
    chk("pri_w_arready", m0_arready, 0);
    step(); m0_awvalid = 0; m0_wvalid = 0;
    smp();
    chk("pri_rearb_s_arvalid", s_arvalid, 0);
    chk("pri_rearb_arready", m0_arready, 0);
    step(); smp();
    chk("pri_r_s_arvalid", s_arvalid, 1);
    chk("pri_r_s_araddr", s_araddr, 32'h10);
    chk("pri_r_arready", m0_arready, 1);
    step(); m0_arvalid = 0; s_rvalid = 1; s_rdata = 32'hA5A5;
    smp();
    chk("pri_r_rvalid", m0_rvalid, 1);
    chk("pri_r_rdata", m0_rdata, 32'hA5A5);

    // Backpressure on m0's read while m1 waits
    step(); s_rvalid = 0; s_rdata = '0; m0_rready = 0;
    m0_araddr = 32'h30; m0_arvalid = 1;
    smp();
    step();
    m1_awaddr = 32'h300; m1_wdata = 32'h33; m1_awvalid = 1; m1_wvalid = 1;
    smp();
    chk("bp_m0_arready", m0_arready, 1);
    chk("bp_m1_awready_rgnt", m1_awready, 0);
    step(); m0_arvalid = 0; s_rvalid = 1; s_rdata = 32'hBEEF;
    for (int k = 0; k < 5; k++) begin
      smp();
      chk($sformatf("bp_hold_m0_rvalid_c%0d", k), m0_rvalid, 1);
      chk($sformatf("bp_hold_s_rready_c%0d", k), s_rready, 0);
      chk($sformatf("bp_hold_m1_awready_c%0d", k), m1_awready, 0);
      chk($sformatf("bp_hold_s_awvalid_c%0d", k), s_awvalid, 0);
      step();
    end
    m0_rready = 1;
    smp();
    chk("bp_s_rready", s_rready, 1);
    chk("bp_m0_rdata", m0_rdata, 32'hBEEF);
    step(); s_rvalid = 0; s_rdata = '0; m0_rready = 0;
    smp();
    chk("bp_arb_m1_awready", m1_awready, 0);
    step(); smp();
    chk("bp_m1_awready", m1_awready, 1);
    chk("bp_m1_s_awaddr", s_awaddr, 32'h300);
    chk("bp_m1_s_wdata", s_wdata, 32'h33);

    // m0 write moves rr to m1 before the reset test
    step(); m1_awvalid = 0; m1_wvalid = 0;
    m0_awaddr = 32'h40; m0_awvalid = 1; m0_wvalid = 1;
    smp();
    step(); smp();
    chk("pre_rst_m0_awready", m0_awready, 1);

    // Reset while m1 sits in RRESP
    step(); m0_awvalid = 0; m0_wvalid = 0;
    m1_araddr = 32'h44; m1_arvalid = 1; m1_rready = 0;
    smp();
    step(); smp();
    chk("rst_rd_m1_arready", m1_arready, 1);
    step(); m1_arvalid = 0; s_rvalid = 1; s_rdata = 32'h77;
    smp();
    chk("rst_rresp_m1_rvalid", m1_rvalid, 1);
    chk("rst_rresp_m1_rdata", m1_rdata, 32'h77);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_m1_rvalid", m1_rvalid, 0);
    chk("rst_mid_m1_rdata", m1_rdata, 0);
    chk("rst_mid_s_rready", s_rready, 0);
    chk("rst_mid_m1_arready", m1_arready, 0);
    step(); s_rvalid = 0; s_rdata = '0; rst_n = 1;
    m0_awaddr = 32'h50; m0_awvalid = 1; m0_wvalid = 1;
    m1_awaddr = 32'h60; m1_awvalid = 1; m1_wvalid = 1;
    smp();
    chk("post_rst_idle_m0_awready", m0_awready, 0);
    step(); smp();
    chk("post_rst_m0_awready", m0_awready, 1);
    chk("post_rst_m1_awready", m1_awready, 0);
    chk("post_rst_s_awaddr", s_awaddr, 32'h50);
    step(); m0_awvalid = 0; m0_wvalid = 0; m1_awvalid = 0; m1_wvalid = 0;

`ifdef SYSIO_ARB_LOCK_EN
    // rr now points at m1; with the lock m1 must win three times in a row
    m1_lock = 1;
    m0_awvalid = 1; m0_wvalid = 1; m1_awvalid = 1; m1_wvalid = 1;
    for (int k = 0; k < 6; k++) begin
      smp();
      chk($sformatf("lock_m1_grant_c%0d", k), m1_awready, (k % 2 == 1));
      chk($sformatf("lock_m0_grant_c%0d", k), m0_awready, 0);
      step();
    end
    m1_lock = 0;
    m0_awvalid = 0; m0_wvalid = 0; m1_awvalid = 0; m1_wvalid = 0;
`endif

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sysio_axil_arb.md
Name: sysio_axil_arb

Overview:
- Two-master to one-slave AXI4-Lite arbiter placed in front of the sysio peripheral slave port.
- Shares the sysio register space between the core load/store unit (m0) and a second requester (m1, debug/DMA).
- Uses the sysio channel subset only: AW, W, AR and R. There is no B channel; a write completes on the joint AW+W handshake.
- Serializes transactions with round-robin fairness and routes each R response back to the master that issued the read.

Parameters:
- ADDR_W, 32, address width (matches `MemAddrBus).
- DATA_W, 32, data width (matches `MemBus); wstrb width is DATA_W/8.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mN_axi_awaddr  in  ADDR_W  master N write address (N = 0,1 for every mN_ line)
- mN_axi_awvalid  in  1  write address valid
- mN_axi_awready  out  1  write address ready
- mN_axi_wdata  in  DATA_W  write data
- mN_axi_wstrb  in  DATA_W/8  write strobes
- mN_axi_wvalid  in  1  write data valid
- mN_axi_wready  out  1  write data ready
- mN_axi_araddr  in  ADDR_W  read address
- mN_axi_arvalid  in  1  read address valid
- mN_axi_arready  out  1  read address ready
- mN_axi_rdata  out  DATA_W  read data
- mN_axi_rvalid  out  1  read data valid
- mN_axi_rready  in  1  read data ready
- s_axi_awaddr/awvalid/wdata/wstrb/wvalid/araddr/arvalid/rready  out  (widths as above)  to sysio
- s_axi_awready/wready/arready/rdata/rvalid  in  (widths as above)  from sysio
- m1_lock_i  in  1  m1 atomic-sequence lock (present only with SYSIO_ARB_LOCK_EN)

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - State = IDLE; round-robin pointer rr = 0 (m0 preferred).
  - All s_* valids and rready = 0; all mN ready/valid outputs = 0; all data outputs = 0.
- Request definitions: wreqN = mN_awvalid & mN_wvalid; rreqN = mN_arvalid; reqN = wreqN | rreqN.
- State machine, encoded as a registered state plus a registered grant index g:
  - IDLE:
    - If no reqN, stay in IDLE.
    - Otherwise pick g: if both masters request, g = rr; else g = the requesting master.
    - Within master g, write has priority over read: wreqg -> WGNT, else -> RGNT.
    - Arbitration costs exactly 1 cycle; no master sees ready in IDLE.
  - WGNT:
    - Slave AW/W signals are driven from mg; s_awvalid = mg_awvalid, s_wvalid = mg_wvalid.
    - mg_awready = s_awready and mg_wready = s_wready (combinational pass-through).
    - On s_awready & s_wready: -> IDLE, rr = ~g.
  - RGNT:
    - Slave AR signals are driven from mg; mg_arready = s_arready.
    - On s_arvalid & s_arready: -> RRESP.
  - RRESP:
    - mg_rvalid = s_rvalid, mg_rdata = s_rdata, s_rready = mg_rready.
    - On s_rvalid & s_rready: -> IDLE, rr = ~g.
- Non-granted master:
  - All of its ready outputs, rvalid and rdata = 0.
  - Its request is held pending; AXI rule: valid is held until handshake.
- Slave signals outside their own state:
  - s_awvalid, s_wvalid and s_arvalid = 0 outside WGNT/RGNT.
  - s_rready = 0 outside RRESP.
  - Slave address/data outputs = 0 outside their state.
- Per-transaction latency: 1 arbitration cycle plus the slave's handshake time. Reads stay serialized, with only one outstanding read.
- Fairness: once both masters are continuously requesting, grants strictly alternate m0, m1, m0, ...
- Defensive abort: if the granted master drops its request in WGNT/RGNT before the handshake, -> IDLE with rr unchanged.
- Reset asserted mid-transaction: immediate return to the reset state.
  - Sysio is reset by the same rst_n, so no stale R response can follow.
- Stray s_rvalid outside RRESP: not forwarded; s_rready stays 0.

Optional Feature:
- Macro SYSIO_ARB_LOCK_EN.
- Defined:
  - m1_lock_i port exists.
  - While m1_lock_i = 1 at the IDLE decision and m1 requests, g = 1 regardless of rr, and rr is not advanced.
  - This allows atomic multi-access sequences from m1 (e.g. fpioa remap plus gpio set).
  - m0 may be starved while the lock is held; this is by design.
- Undefined: port absent; pure round-robin.

Decomposition:
- Shared package/defines: state encoding (IDLE = 2'd0, WGNT = 2'd1, RGNT = 2'd2, RRESP = 2'd3) and the `MemAddrBus/`MemBus widths.
- One sub-module, axil_rr_pick2: 2-input round-robin picker (req[1:0], rr, lock -> g).
- Channel muxing stays in the top module.

Test Plan:
- Single write:
  - m0 writes awaddr = 0x0000_0400, wdata = 0x0000_00FF, wstrb = 4'hF.
  - Sysio sees s_awvalid the cycle after the request.
  - m0_awready = m0_wready = 1 for exactly one cycle; m1 readies stay 0.
- Single read:
  - m1 reads araddr = 0x0000_0F00; slave returns 0x1234_5678 after 3 cycles.
  - m1_rvalid = 1 with rdata 0x1234_5678; m0_rvalid stays 0.
- Contention after reset:
  - m0 and m1 both assert writes in the same cycle.
  - m0 is granted first, then m1; with continuous requests, the next 4 grants are m0, m1, m0, m1.
- Write/read priority within one master:
  - m0 asserts a write and a read together.
  - Write completes first; the read is granted only after re-arbitration.
- Backpressure:
  - m0 read with m0_rready held low for 5 cycles.
  - Arbiter stays in RRESP and m1 receives no grant during those cycles.
  - After rready rises, m1's pending request is granted 1 cycle after the R handshake.
- Reset in RRESP:
  - Assert rst_n = 0 while in RRESP.
  - All outputs are 0 in the same cycle; after release, the first grant goes to m0.
  - With SYSIO_ARB_LOCK_EN and m1_lock_i = 1, three consecutive grants go to m1 despite continuous m0 requests.
